// File: rtl/iir_ctrl_pkg.sv
// Shared types and constants for the notch-IIR configuration sequencer.
// Build option IIR_CTRL_VERIFY_EN is consumed by iir_cfg_ctrl, not here.
package iir_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_WRITE  = 3'd2,
        ST_VERIFY = 3'd3,
        ST_SETTLE = 3'd4
    } ctrl_state_t;

    localparam logic [1:0] SEL_1MHZ   = 2'd0;
    localparam logic [1:0] SEL_2MHZ   = 2'd1;
    localparam logic [1:0] SEL_2_4MHZ = 2'd2;
    localparam logic [1:0] SEL_BYP    = 2'd3;

    localparam int COEFF_WIDTH_DEF = 20;

    typedef logic signed [COEFF_WIDTH_DEF-1:0] coeff_t;

    // Filter select to one-hot, bit order matching the bypass mask.
    function automatic logic [2:0] sel_onehot(input logic [1:0] sel);
        logic [2:0] oh;
        case (sel)
            SEL_1MHZ:   oh = 3'b001;
            SEL_2MHZ:   oh = 3'b010;
            SEL_2_4MHZ: oh = 3'b100;
            default:    oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/iir_status_sticky.sv
// Single sticky status bit: set has priority over clear.
module iir_status_sticky (
    input  logic clk,
    input  logic rst_n,
    input  logic i_set,
    input  logic i_clr,
    output logic o_flag
);

    logic r_flag;

    // Sticky flag register, set dominates a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag <= 1'b0;
        end else if (i_set) begin
            r_flag <= 1'b1;
        end else if (i_clr) begin
            r_flag <= 1'b0;
        end else begin
            r_flag <= r_flag;
        end
    end

    assign o_flag = r_flag;

endmodule

// File: rtl/iir_cfg_ctrl.sv
// Coefficient-set sequencer for the three notch IIR sections (load, write, settle).
// Build option: `define IIR_CTRL_VERIFY_EN adds the readback VERIFY state.
module iir_cfg_ctrl
    import iir_ctrl_pkg::*;
#(
    parameter int         COEFF_WIDTH   = 20,
    parameter int         COEFF_DEPTH   = 5,
    parameter int         SETTLE_CYCLES = 8,
    parameter logic [2:0] BYPASS_RST    = 3'b000
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               cfg_valid,
    output logic                               cfg_ready,
    input  logic [1:0]                         cfg_sel,
    input  logic [COEFF_WIDTH-1:0]             cfg_data,
    input  logic                               cfg_last,
    output logic                               coeff_wr_en_1MHz,
    output logic                               coeff_wr_en_2MHz,
    output logic                               coeff_wr_en_2_4MHz,
    output logic [COEFF_WIDTH*COEFF_DEPTH-1:0] coeff_bus,
    input  logic [COEFF_WIDTH*COEFF_DEPTH-1:0] coeff_out_1MHz,
    input  logic [COEFF_WIDTH*COEFF_DEPTH-1:0] coeff_out_2MHz,
    input  logic [COEFF_WIDTH*COEFF_DEPTH-1:0] coeff_out_2_4MHz,
    output logic                               bypass_1MHz,
    output logic                               bypass_2MHz,
    output logic                               bypass_2_4MHz,
    input  logic                               overflow_1MHz,
    input  logic                               overflow_2MHz,
    input  logic                               overflow_2_4MHz,
    input  logic                               underflow_1MHz,
    input  logic                               underflow_2MHz,
    input  logic                               underflow_2_4MHz,
    input  logic                               status_clr,
    output logic [2:0]                         sts_ovf,
    output logic [2:0]                         sts_unf,
    output logic                               busy,
    output logic                               cfg_done,
    output logic                               cfg_err
);

    localparam int BUS_W = COEFF_WIDTH * COEFF_DEPTH;
    localparam int IDX_W = $clog2(COEFF_DEPTH);
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(COEFF_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(SETTLE_CYCLES - 2);
    localparam logic             DONE_ON_ENTRY = (SETTLE_CYCLES == 1) ? 1'b1 : 1'b0;

    ctrl_state_t            r_state;
    logic                   r_ready;
    logic                   r_busy;
    logic [IDX_W-1:0]       r_idx;
    logic [1:0]             r_tgt;
    logic [COEFF_WIDTH-1:0] r_stage [COEFF_DEPTH];
    logic [BUS_W-1:0]       r_shadow;
    logic [2:0]             r_mask;
    logic [2:0]             r_force;
    logic [2:0]             r_wr;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_mism;
    logic                   r_done;
    logic                   r_err;

    logic                   w_xfer;
    logic                   w_mism;
    logic [2:0]             w_ovf_in;
    logic [2:0]             w_unf_in;
    logic [2:0]             w_sts_ovf;
    logic [2:0]             w_sts_unf;

    assign w_xfer = cfg_valid & r_ready;

`ifdef IIR_CTRL_VERIFY_EN
    logic [BUS_W-1:0] w_readback;

    // Readback mux for the filter currently being committed.
    always_comb begin
        w_readback = {BUS_W{1'b0}};
        case (r_tgt)
            SEL_1MHZ:   w_readback = coeff_out_1MHz;
            SEL_2MHZ:   w_readback = coeff_out_2MHz;
            SEL_2_4MHZ: w_readback = coeff_out_2_4MHz;
            default:    w_readback = {BUS_W{1'b0}};
        endcase
    end

    assign w_mism = (w_readback != r_shadow);
`else
    logic w_unused_readback;
    assign w_unused_readback = ^{coeff_out_1MHz, coeff_out_2MHz, coeff_out_2_4MHz};
    assign w_mism = 1'b0;
`endif

    // Sequencer: words are staged so an aborted set never disturbs the committed shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
            r_idx    <= {IDX_W{1'b0}};
            r_tgt    <= 2'd0;
            for (int k = 0; k < COEFF_DEPTH; k++) begin
                r_stage[k] <= {COEFF_WIDTH{1'b0}};
            end
            r_shadow <= {BUS_W{1'b0}};
            r_mask   <= BYPASS_RST;
            r_force  <= 3'b000;
            r_wr     <= 3'b000;
            r_cnt    <= {CNT_W{1'b0}};
            r_mism   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_wr   <= 3'b000;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_ready <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_xfer) begin
                        if (cfg_sel == SEL_BYP) begin
                            r_mask <= cfg_data[2:0];
                        end else begin
                            r_stage[0] <= cfg_data;
                            r_tgt      <= cfg_sel;
                            r_idx      <= IDX_W'(1);
                            r_busy     <= 1'b1;
                            r_state    <= ST_LOAD;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (w_xfer) begin
                        if ((cfg_sel != r_tgt) || (cfg_last != (r_idx == IDX_LAST))) begin
                            r_err   <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else if (r_idx == IDX_LAST) begin
                            for (int k = 0; k < COEFF_DEPTH - 1; k++) begin
                                r_shadow[k*COEFF_WIDTH +: COEFF_WIDTH] <= r_stage[k];
                            end
                            r_shadow[(COEFF_DEPTH-1)*COEFF_WIDTH +: COEFF_WIDTH] <= cfg_data;
                            r_wr    <= sel_onehot(r_tgt);
                            r_force <= sel_onehot(r_tgt);
                            r_ready <= 1'b0;
                            r_state <= ST_WRITE;
                        end else begin
                            r_stage[r_idx] <= cfg_data;
                            r_idx          <= r_idx + IDX_W'(1);
                        end
                    end else begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_WRITE: begin
                    r_ready <= 1'b0;
`ifdef IIR_CTRL_VERIFY_EN
                    r_state <= ST_VERIFY;
`else
                    r_cnt   <= {CNT_W{1'b0}};
                    r_mism  <= 1'b0;
                    r_done  <= DONE_ON_ENTRY;
                    r_state <= ST_SETTLE;
`endif
                end
                ST_VERIFY: begin
                    r_ready <= 1'b0;
                    r_cnt   <= {CNT_W{1'b0}};
                    r_mism  <= w_mism;
                    r_err   <= w_mism;
                    r_done  <= DONE_ON_ENTRY & ~w_mism;
                    r_state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (r_cnt == CNT_LAST) begin
                        r_force <= 3'b000;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_ready <= 1'b0;
                        r_cnt   <= r_cnt + CNT_W'(1);
                        r_done  <= (r_cnt == CNT_PRE) & ~r_mism;
                    end
                end
                default: begin
                    r_force <= 3'b000;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_ovf_in = {overflow_2_4MHz, overflow_2MHz, overflow_1MHz};
    assign w_unf_in = {underflow_2_4MHz, underflow_2MHz, underflow_1MHz};

    for (genvar g = 0; g < 3; g++) begin : g_sticky
        iir_status_sticky u_ovf (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_set  (w_ovf_in[g]),
            .i_clr  (status_clr),
            .o_flag (w_sts_ovf[g])
        );
        iir_status_sticky u_unf (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_set  (w_unf_in[g]),
            .i_clr  (status_clr),
            .o_flag (w_sts_unf[g])
        );
    end

    assign cfg_ready          = r_ready;
    assign busy               = r_busy;
    assign cfg_done           = r_done;
    assign cfg_err            = r_err;
    assign coeff_bus          = r_shadow;
    assign coeff_wr_en_1MHz   = r_wr[0];
    assign coeff_wr_en_2MHz   = r_wr[1];
    assign coeff_wr_en_2_4MHz = r_wr[2];
    assign bypass_1MHz        = r_mask[0] | r_force[0];
    assign bypass_2MHz        = r_mask[1] | r_force[1];
    assign bypass_2_4MHz      = r_mask[2] | r_force[2];
    assign sts_ovf            = w_sts_ovf;
    assign sts_unf            = w_sts_unf;

endmodule

// File: tb/tb_iir_cfg_ctrl.sv
// Directed bench for iir_cfg_ctrl with a commit scoreboard and filter readback model.
// Honors IIR_CTRL_VERIFY_EN for the expected commit timing.
module tb_iir_cfg_ctrl;

    localparam int W    = 20;
    localparam int D    = 5;
    localparam int S    = 8;
    localparam int BUSW = W * D;
`ifdef IIR_CTRL_VERIFY_EN
    localparam int VER = 1;
`else
    localparam int VER = 0;
`endif

    typedef struct {
        logic [2:0]      onehot;
        logic [BUSW-1:0] bus;
    } commit_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cfg_valid = 1'b0;
    logic            cfg_ready;
    logic [1:0]      cfg_sel = 2'd0;
    logic [W-1:0]    cfg_data = '0;
    logic            cfg_last = 1'b0;
    logic            wr1, wr2, wr24;
    logic [BUSW-1:0] coeff_bus;
    logic [BUSW-1:0] out1, out2, out24;
    logic [BUSW-1:0] mem1 = '0, mem2 = '0, mem24 = '0;
    logic [BUSW-1:0] corr_mask;
    logic            corrupt = 1'b0;
    logic            byp1, byp2, byp24;
    logic [2:0]      ovf = 3'b000, unf = 3'b000;
    logic            status_clr = 1'b0;
    logic [2:0]      sts_ovf, sts_unf;
    logic            busy, cfg_done, cfg_err;

    int checks = 0;
    int errors = 0;
    commit_t sb_q[$];
    logic [BUSW-1:0] exp_shadow = '0;

    int win_wr[3];
    int win_byp[3];
    int win_done, win_err, done_idx, rdy_idx;

    always #5 clk = ~clk;

    iir_cfg_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_sel(cfg_sel),
        .cfg_data(cfg_data), .cfg_last(cfg_last),
        .coeff_wr_en_1MHz(wr1), .coeff_wr_en_2MHz(wr2), .coeff_wr_en_2_4MHz(wr24),
        .coeff_bus(coeff_bus),
        .coeff_out_1MHz(out1), .coeff_out_2MHz(out2), .coeff_out_2_4MHz(out24),
        .bypass_1MHz(byp1), .bypass_2MHz(byp2), .bypass_2_4MHz(byp24),
        .overflow_1MHz(ovf[0]), .overflow_2MHz(ovf[1]), .overflow_2_4MHz(ovf[2]),
        .underflow_1MHz(unf[0]), .underflow_2MHz(unf[1]), .underflow_2_4MHz(unf[2]),
        .status_clr(status_clr), .sts_ovf(sts_ovf), .sts_unf(sts_unf),
        .busy(busy), .cfg_done(cfg_done), .cfg_err(cfg_err)
    );

    // Filter coefficient memories, optionally corrupting word 2 on readback.
    always @(posedge clk) begin
        if (wr1)  mem1  <= coeff_bus;
        if (wr2)  mem2  <= coeff_bus;
        if (wr24) mem24 <= coeff_bus;
    end
    assign out1  = corrupt ? (mem1  ^ corr_mask) : mem1;
    assign out2  = corrupt ? (mem2  ^ corr_mask) : mem2;
    assign out24 = corrupt ? (mem24 ^ corr_mask) : mem24;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expected commit.
    always @(negedge clk) begin
        if (wr1 | wr2 | wr24) begin
            chk("sb_commit_expected", 128'(sb_q.size() > 0), 128'(1));
            if (sb_q.size() > 0) begin
                commit_t c;
                c = sb_q.pop_front();
                chk("sb_strobe", 128'({wr24, wr2, wr1}), 128'(c.onehot));
                chk("sb_bus", 128'(coeff_bus), 128'(c.bus));
            end
        end
    end

    task automatic send(input logic [1:0] sel, input logic [W-1:0] data, input logic last);
        int n;
        n = 0;
        @(negedge clk);
        cfg_valid = 1'b1; cfg_sel = sel; cfg_data = data; cfg_last = last;
        while (!cfg_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("ready_timeout", 128'(0), 128'(1));
        @(posedge clk);
        #1 cfg_valid = 1'b0; cfg_last = 1'b0;
    endtask

    // Full well-formed set; expectation is queued before the last word goes out.
    task automatic send_set(input logic [1:0] sel);
        logic [BUSW-1:0] bus;
        logic [W-1:0] w;
        logic [2:0] oh;
        bus = '0;
        for (int k = 0; k < D; k++) begin
            w = W'($urandom());
            bus[k*W +: W] = w;
            if (k == D - 1) begin
                oh = 3'b001 << sel;
                sb_q.push_back('{onehot: oh, bus: bus});
                exp_shadow = bus;
            end
            send(sel, w, k == D - 1);
        end
    endtask

    task automatic observe(input int n);
        for (int j = 0; j < 3; j++) begin
            win_wr[j] = 0; win_byp[j] = 0;
        end
        win_done = 0; win_err = 0; done_idx = -1; rdy_idx = -1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            win_wr[0] += int'(wr1); win_wr[1] += int'(wr2); win_wr[2] += int'(wr24);
            win_byp[0] += int'(byp1); win_byp[1] += int'(byp2); win_byp[2] += int'(byp24);
            win_done += int'(cfg_done);
            win_err  += int'(cfg_err);
            if (cfg_done && done_idx < 0) done_idx = i;
            if (cfg_ready && rdy_idx < 0) rdy_idx = i;
        end
    endtask

    initial begin
        corr_mask = '0;
        corr_mask[2*W +: W] = 20'h00010;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", 128'(cfg_ready), 128'(0));
        chk("rst_bypass", 128'({byp24, byp2, byp1}), 128'(3'b000));
        chk("rst_sts", 128'({sts_unf, sts_ovf}), 128'(0));
        chk("rst_flags", 128'({busy, cfg_done, cfg_err, wr24, wr2, wr1}), 128'(0));
        chk("rst_bus", 128'(coeff_bus), 128'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", 128'(cfg_ready), 128'(1));

        // Bypass mask word
        send(2'd3, 20'h00005, 1'b0);
        chk("mask_101", 128'({byp24, byp2, byp1}), 128'(3'b101));
        chk("mask_idle", 128'(busy), 128'(0));
        send(2'd3, 20'h00000, 1'b1);
        chk("mask_000", 128'({byp24, byp2, byp1}), 128'(3'b000));

        // Clean commit to the 2 MHz section
        send_set(2'd1);
        observe(14);
        chk("c1_wr_2m", 128'(win_wr[1]), 128'(1));
        chk("c1_wr_others", 128'(win_wr[0] + win_wr[2]), 128'(0));
        chk("c1_byp_2m", 128'(win_byp[1]), 128'(S + 1 + VER));
        chk("c1_byp_others", 128'(win_byp[0] + win_byp[2]), 128'(0));
        chk("c1_done_cnt", 128'(win_done), 128'(1));
        chk("c1_done_idx", 128'(done_idx), 128'(S + VER));
        chk("c1_ready_idx", 128'(rdy_idx), 128'(S + VER + 1));
        chk("c1_err", 128'(win_err), 128'(0));
        chk("c1_bus", 128'(coeff_bus), 128'(exp_shadow));

        // Corrupted readback on word 2
        corrupt = 1'b1;
        send_set(2'd0);
        observe(14);
        corrupt = 1'b0;
        chk("vf_wr_1m", 128'(win_wr[0]), 128'(1));
        chk("vf_err", 128'(win_err), 128'(VER));
        chk("vf_done", 128'(win_done), 128'(1 - VER));

        // Framing: cfg_last on word 2
        send(2'd2, 20'h11111, 1'b0);
        send(2'd2, 20'h22222, 1'b0);
        send(2'd2, 20'h33333, 1'b1);
        observe(6);
        chk("fr_last_err", 128'(win_err), 128'(1));
        chk("fr_last_wr", 128'(win_wr[0] + win_wr[1] + win_wr[2]), 128'(0));
        chk("fr_last_bus", 128'(coeff_bus), 128'(exp_shadow));
        chk("fr_last_idle", 128'({busy, cfg_ready}), 128'(2'b01));

        // Framing: target switched mid-set
        send(2'd0, 20'h44444, 1'b0);
        send(2'd0, 20'h55555, 1'b0);
        send(2'd2, 20'h66666, 1'b0);
        observe(6);
        chk("fr_sel_err", 128'(win_err), 128'(1));
        chk("fr_sel_wr", 128'(win_wr[0] + win_wr[1] + win_wr[2]), 128'(0));
        chk("fr_sel_bus", 128'(coeff_bus), 128'(exp_shadow));

        // Framing: word 4 without cfg_last
        for (int k = 0; k < D; k++) send(2'd0, W'(k + 7), 1'b0);
        observe(6);
        chk("fr_nolast_err", 128'(win_err), 128'(1));
        chk("fr_nolast_wr", 128'(win_wr[0] + win_wr[1] + win_wr[2]), 128'(0));

        // Commit to 2.4 MHz after errors recovers normally
        send_set(2'd2);
        observe(14);
        chk("c2_wr_24m", 128'(win_wr[2]), 128'(1));
        chk("c2_done", 128'(win_done), 128'(1));

        // Sticky status flags
        @(negedge clk); ovf = 3'b100; unf = 3'b001;
        @(negedge clk); ovf = 3'b000; unf = 3'b000;
        repeat (3) @(negedge clk);
        chk("sts_ovf_hold", 128'(sts_ovf), 128'(3'b100));
        chk("sts_unf_hold", 128'(sts_unf), 128'(3'b001));
        ovf = 3'b100; status_clr = 1'b1;
        @(negedge clk); ovf = 3'b000; status_clr = 1'b0;
        @(negedge clk);
        chk("sts_set_wins", 128'(sts_ovf), 128'(3'b100));
        chk("sts_clr_unf", 128'(sts_unf), 128'(3'b000));
        status_clr = 1'b1;
        @(negedge clk); status_clr = 1'b0;
        @(negedge clk);
        chk("sts_clr", 128'(sts_ovf), 128'(3'b000));

        // Reset asserted as word 4 is presented
        for (int k = 0; k < D - 1; k++) send(2'd2, W'(k + 100), 1'b0);
        @(negedge clk);
        cfg_valid = 1'b1; cfg_sel = 2'd2; cfg_data = 20'h0ABCD; cfg_last = 1'b1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rm_wr", 128'({wr24, wr2, wr1}), 128'(3'b000));
        chk("rm_bus", 128'(coeff_bus), 128'(0));
        chk("rm_outs", 128'({cfg_ready, busy, cfg_done, cfg_err, byp24, byp2, byp1}), 128'(0));
        @(negedge clk);
        cfg_valid = 1'b0; cfg_last = 1'b0;
        rst_n = 1'b1;
        observe(12);
        chk("rm_no_strobe", 128'(win_wr[0] + win_wr[1] + win_wr[2]), 128'(0));
        chk("rm_ready", 128'(cfg_ready), 128'(1));

        chk("sb_empty", 128'(sb_q.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iir_cfg_ctrl.md
# iir_cfg_ctrl

Configuration sequencer for the three-stage notch IIR chain (1 MHz, 2 MHz, 2.4 MHz sections). Accepts coefficient sets as a stream of single words over a valid/ready handshake and assembles each 5-word set in a shadow register. It then commits the set to the selected filter with a one-cycle write strobe, forcing that filter into bypass while it settles. It also owns the per-filter bypass mask and sticky overflow/underflow status.

## Interface
- COEFF_WIDTH, 20, coefficient word width (signed, Q2.18)
- COEFF_DEPTH, 5, words per filter set (b0,b1,b2,a1,a2)
- SETTLE_CYCLES, 8, cycles the target filter stays force-bypassed after a write (≥1)
- BYPASS_RST, 3'b000, bypass mask after reset; bit0=1MHz, bit1=2MHz, bit2=2.4MHz
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cfg_valid  in  1  config word valid
- cfg_ready  out  1  controller can accept a word
- cfg_sel  in  2  0=1MHz, 1=2MHz, 2=2.4MHz, 3=bypass-mask word
- cfg_data  in  COEFF_WIDTH  coefficient word, or mask in [2:0] when cfg_sel=3
- cfg_last  in  1  marks final word of a coefficient set
- coeff_wr_en_1MHz / _2MHz / _2_4MHz  out  1 each  one-cycle write strobe to the filter
- coeff_bus  out  COEFF_WIDTH x COEFF_DEPTH  shadow set, fanned out to all three coeff_in ports
- coeff_out_1MHz / _2MHz / _2_4MHz  in  COEFF_WIDTH x COEFF_DEPTH each  filter readback
- bypass_1MHz / _2MHz / _2_4MHz  out  1 each  effective bypass to the filters
- overflow_*/underflow_* (three of each)  in  1 each  filter saturation flags
- status_clr  in  1  clears all sticky flags
- sts_ovf, sts_unf  out  3 each  sticky saturation flags, same bit order as the mask
- busy  out  1  high in every state except IDLE
- cfg_done  out  1  one-cycle pulse when a set is committed
- cfg_err  out  1  one-cycle pulse on a framing or readback error

## Operation
- FSM: IDLE → LOAD → WRITE → VERIFY → SETTLE → IDLE.
- A word transfers on a rising edge with cfg_valid & cfg_ready. cfg_ready=1 only in IDLE and LOAD.
- IDLE, cfg_sel=3: the user mask takes cfg_data[2:0], effective from the next cycle. Stay in IDLE. cfg_last is ignored.
- IDLE, cfg_sel 0..2: store word 0, latch the target, go to LOAD (index=1).
- LOAD: store the word at the current index and increment.
  - Error: cfg_sel differs from the latched target, cfg_last arrives before index 4, or index 4 arrives without cfg_last.
  - On error: pulse cfg_err, discard the partial set (previous shadow retained), return to IDLE.
  - Word 4 with cfg_last → WRITE.
- WRITE: the target's coeff_wr_en is high for exactly this cycle. coeff_bus holds the new set.
- VERIFY: compare the target's coeff_out with the shadow. On mismatch, pulse cfg_err (no cfg_done), still go to SETTLE.
- SETTLE: count SETTLE_CYCLES, then go to IDLE. cfg_done pulses on the last SETTLE cycle, unless a mismatch occurred.
- Effective bypass for each filter = user mask bit, OR (target bit AND state ∈ {WRITE, VERIFY, SETTLE}).
- Sticky flags: a bit sets when its input flag is high and clears on status_clr. If set and status_clr coincide, set wins.

## Timing
- Reset values:
  - cfg_ready=0 during reset, 1 in the first cycle after release.
  - All coeff_wr_en=0, coeff_bus=0, busy=0, cfg_done=0, cfg_err=0, sts_*=0.
  - Bypass outputs = BYPASS_RST. State = IDLE.
- Last word accepted at edge E:
  - WRITE occupies cycle E..E+1; VERIFY E+1..E+2.
  - SETTLE runs SETTLE_CYCLES cycles.
  - cfg_done is high on cycle E+2+SETTLE_CYCLES−1; cfg_ready returns 1 the cycle after.
- coeff_bus is stable from the acceptance of word 4 until the next set's word 0 is accepted.
- A mask word is not accepted while busy (cfg_ready=0). No mask update can land mid-commit.
- Reset asserted mid-sequence: immediate abort. No write strobe is issued; the shadow is cleared.

## Configuration
- IIR_CTRL_VERIFY_EN defined: the VERIFY state exists and readback mismatches raise cfg_err.
- IIR_CTRL_VERIFY_EN undefined: WRITE goes directly to SETTLE, and cfg_done moves one cycle earlier. coeff_out_* ports remain but are unused, and cfg_err comes only from framing errors.

## Structure
- Package iir_ctrl_pkg holds:
  - the state enum (IDLE, LOAD, WRITE, VERIFY, SETTLE)
  - the filter-select localparams (SEL_1MHZ=0, SEL_2MHZ=1, SEL_2_4MHZ=2, SEL_BYP=3)
  - the coefficient typedef, signed [COEFF_WIDTH-1:0]
- Sub-module iir_status_sticky: one set/clear flag with set priority, instantiated six times.

## Test plan
- After reset → bypass outputs=BYPASS_RST, sts=0, cfg_ready=1. A mask word with sel=3, data=3'b101 → bypass_1MHz=1, _2MHz=0, _2_4MHz=1 the next cycle.
- Five words to sel=1 (last on word 4), SETTLE_CYCLES=8:
  - coeff_wr_en_2MHz pulses exactly once, 1 cycle after word 4.
  - bypass_2MHz is forced high for 10 cycles (9 without the macro).
  - cfg_done pulses once; the other strobes stay 0.
- Readback model returns a corrupted word 2 → cfg_err pulses in VERIFY and cfg_done does not pulse. Without the macro → cfg_done pulses normally.
- Framing errors → cfg_err pulses, no write strobe, previous shadow retained:
  - cfg_last on word 2
  - cfg_sel switched from 0 to 2 mid-set
- overflow_2_4MHz pulsed once → sts_ovf[2] stays 1. status_clr asserted in the same cycle as a new overflow → stays 1. status_clr alone → clears.
- rst_n asserted in the cycle word 4 is accepted → no coeff_wr_en pulse, all outputs at reset values.
